// File: rtl/ov7670_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_cfg_pkg
// Shared types and constants for the OV7670 SCCB configuration controller.
//   cfg_state_e   : sequencing FSM states of ov7670_sccb_config
//   sccb_phase_e  : phase FSM states of sccb_write_engine
//   sccb_frame()  : builds the 27-bit serial frame (addr, reg, value, each
//                   followed by a released don't-care ninth bit)
// ---------------------------------------------------------------------------
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESEND,
    ST_SETTLE,
    ST_LOAD,
    ST_SEND,
    ST_RSTWAIT,
    ST_ADVANCE,
    ST_DONE
  } cfg_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_BIT,
    PH_STOP
  } sccb_phase_e;

  localparam logic [15:0] SCCB_SOFT_RESET = 16'h1280;
  localparam logic [15:0] ROM_END         = 16'hFFFF;
  localparam int          ROM_SETTLE      = 2;
  localparam int          SCCB_BITS       = 27;

  // A '1' in a don't-care slot means SIOD is released (pull-up drives it).
  function automatic logic [SCCB_BITS-1:0] sccb_frame(input logic [7:0]  addr,
                                                       input logic [15:0] data);
    return {addr, 1'b1, data[15:8], 1'b1, data[7:0], 1'b1};
  endfunction

endpackage

// File: rtl/sccb_write_engine.sv
// ---------------------------------------------------------------------------
// sccb_write_engine
// Issues one three-phase SCCB write: start, 27 data bits, stop.
// Every bit is four quarters of QTR_DIV clk cycles:
//   q0 SIOC low, data driven; q1 SIOC low; q2/q3 SIOC high.
// Ports:
//   clk, resetn   : clock, synchronous active-low reset
//   go            : one-cycle request; data is captured on this edge
//   data[15:0]    : {register, value}
//   sioc          : SCCB clock (registered)
//   siod_oe       : 1 pulls SIOD low, 0 releases it (registered)
//   done          : one-cycle pulse 116*QTR_DIV cycles after the go edge
// Handshake: go is only honoured while the engine is idle; the requester
// must hold off further go pulses until it has seen done.
// ---------------------------------------------------------------------------
module sccb_write_engine
  import ov7670_cfg_pkg::*;
#(
  parameter int          QTR_DIV    = 63,
  parameter logic [7:0]  SLAVE_ADDR = 8'h42
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        go,
  input  logic [15:0] data,
  output logic        sioc,
  output logic        siod_oe,
  output logic        done
);

  localparam int             CW       = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [CW-1:0]  QTR_LAST = CW'(QTR_DIV - 1);
  localparam logic [4:0]     LAST_BIT = 5'(SCCB_BITS - 1);

  sccb_phase_e          phase_q, phase_d;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [1:0]           qtr_q, qtr_d;
  logic [4:0]           bit_q, bit_d;
  logic [SCCB_BITS-1:0] shift_q, shift_d;
  logic                 sioc_q, sioc_d;
  logic                 oe_q, oe_d;
  logic                 done_q, done_d;
  logic                 tick;

  assign tick = (tick_cnt_q == QTR_LAST);

  always_comb begin
    phase_d    = phase_q;
    tick_cnt_d = tick_cnt_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    done_d     = 1'b0;

    if (phase_q == PH_IDLE) begin
      tick_cnt_d = '0;
      if (go) begin
        phase_d = PH_START;
        qtr_d   = 2'd0;
        bit_d   = 5'd0;
        shift_d = sccb_frame(SLAVE_ADDR, data);
      end
    end else if (!tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end else begin
      tick_cnt_d = '0;
      qtr_d      = qtr_q + 2'd1;
      if (qtr_q == 2'd3) begin
        case (phase_q)
          PH_START: phase_d = PH_BIT;
          PH_BIT: begin
            if (bit_q == LAST_BIT) begin
              phase_d = PH_STOP;
            end else begin
              bit_d   = bit_q + 5'd1;
              shift_d = shift_q << 1;
            end
          end
          PH_STOP: begin
            phase_d = PH_IDLE;
            done_d  = 1'b1;
          end
          default: phase_d = PH_IDLE;
        endcase
      end
    end

    // Pin levels are decoded from the next state and registered, so the pins
    // line up with the phase/quarter registers and never glitch.
    sioc_d = 1'b1;
    oe_d   = 1'b0;
    case (phase_d)
      PH_START: begin
        // SIOD falls with SIOC high (start condition), then SIOC drops.
        sioc_d = ~qtr_d[1];
        oe_d   = 1'b1;
      end
      PH_BIT: begin
        sioc_d = qtr_d[1];
        oe_d   = ~shift_d[SCCB_BITS-1];
      end
      PH_STOP: begin
        // SIOD low, then SIOC high, then SIOD released (stop condition).
        sioc_d = (qtr_d != 2'd0);
        oe_d   = ~qtr_d[1];
      end
      default: begin
        sioc_d = 1'b1;
        oe_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase_q    <= PH_IDLE;
      tick_cnt_q <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 5'd0;
      shift_q    <= '0;
      sioc_q     <= 1'b1;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      tick_cnt_q <= tick_cnt_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      sioc_q     <= sioc_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
    end
  end

  assign sioc    = sioc_q;
  assign siod_oe = oe_q;
  assign done    = done_q;

endmodule

// File: rtl/ov7670_sccb_config.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_config
// Walks the OV7670 register ROM from entry 0 to its end marker and writes
// every entry to the camera over SCCB. After the soft-reset command the
// sequence idles RESET_WAIT cycles before the next write.
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   start            : one-cycle pulse, accepted only in IDLE or DONE
//   rom_command      : {register, value} from the ROM
//   rom_finished     : ROM end marker, sampled only in LOAD
//   rom_resend       : one-cycle pulse rewinding the ROM to entry 0
//   rom_advance      : one-cycle pulse stepping the ROM
//   sioc, siod_oe    : SCCB pins (siod_oe=1 pulls SIOD low)
//   busy             : high from accepted start until DONE
//   done             : high in DONE until the next start or reset
// ---------------------------------------------------------------------------
module ov7670_sccb_config
  import ov7670_cfg_pkg::*;
#(
  parameter int         QTR_DIV    = 63,
  parameter int         RESET_WAIT = 25000,
  parameter logic [7:0] SLAVE_ADDR = 8'h42
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [15:0] rom_command,
  input  logic        rom_finished,
  output logic        rom_resend,
  output logic        rom_advance,
  output logic        sioc,
  output logic        siod_oe,
  output logic        busy,
  output logic        done
);

  localparam int             WW          = $clog2(RESET_WAIT + 1);
  localparam logic [WW-1:0]  WAIT_LAST   = WW'(RESET_WAIT - 1);
  localparam int             SW          = (ROM_SETTLE > 1) ? $clog2(ROM_SETTLE) : 1;
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(ROM_SETTLE - 1);

  cfg_state_e    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          eng_go;
  logic          eng_done;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    wait_d   = wait_q;
    cmd_d    = cmd_q;
    eng_go   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_RESEND;
      end
      ST_RESEND: begin
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      // The ROM needs one cycle to move its address and one more for its
      // registered output before rom_command/rom_finished are valid.
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_LOAD;
        else                         settle_d = settle_q + 1'b1;
      end
      ST_LOAD: begin
        if (rom_finished) begin
          state_d = ST_DONE;
        end else begin
          cmd_d   = rom_command;
          eng_go  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (eng_done) begin
          wait_d  = '0;
          state_d = (cmd_q == SCCB_SOFT_RESET) ? ST_RSTWAIT : ST_ADVANCE;
        end
      end
      ST_RSTWAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_ADVANCE;
        else                     wait_d  = wait_q + 1'b1;
      end
      ST_ADVANCE: begin
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      wait_q   <= '0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      wait_q   <= wait_d;
      cmd_q    <= cmd_d;
    end
  end

  assign rom_resend  = (state_q == ST_RESEND);
  assign rom_advance = (state_q == ST_ADVANCE);
  assign done        = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);

  sccb_write_engine #(
    .QTR_DIV    (QTR_DIV),
    .SLAVE_ADDR (SLAVE_ADDR)
  ) u_engine (
    .clk     (clk),
    .resetn  (resetn),
    .go      (eng_go),
    .data    (rom_command),
    .sioc    (sioc),
    .siod_oe (siod_oe),
    .done    (eng_done)
  );

endmodule

// File: doc/ov7670_sccb_config.md
# ov7670_sccb_config

Camera configuration controller that walks the OV7670 register-command ROM from entry 0 to its end marker. For each entry it issues one three-phase SCCB write (slave address, register, value) on the camera's SIOC/SIOD pins. The block sits between the register ROM and the camera pins. It drives the ROM's `resend`/`advance` inputs, samples `command`/`finished`, and reports `done` to the capture pipeline once every register has been written.

## Interface

Parameters:
- `QTR_DIV`, default 63: clk cycles per SCCB quarter-bit. The SCCB bit period is 4·QTR_DIV clk cycles.
- `RESET_WAIT`, default 25000: clk cycles idled after writing the soft-reset command 16'h1280 (1 ms at 25 MHz).
- `SLAVE_ADDR`, default 8'h42: SCCB write address of the camera.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a full configuration pass.
- `rom_command`  in  16  ROM output {register, value}.
- `rom_finished`  in  1  ROM end marker (command == 16'hFFFF).
- `rom_resend`  out  1  one-cycle pulse that rewinds the ROM to entry 0.
- `rom_advance`  out  1  one-cycle pulse that steps the ROM to the next entry.
- `sioc`  out  1  SCCB clock.
- `siod_oe`  out  1  1 pulls SIOD low; 0 releases it (pull-up gives 1).
- `busy`  out  1  high from the accepted `start` until DONE.
- `done`  out  1  high in DONE; held until the next `start` or reset.

## Operation

- FSM states: IDLE, RESEND, SETTLE, LOAD, SEND, RSTWAIT, ADVANCE, DONE.
- IDLE/DONE + `start` → RESEND. `start` in any other state is ignored.
- RESEND: `rom_resend`=1 for exactly one cycle, then → SETTLE.
- SETTLE: wait 2 cycles (ROM address update plus registered output), then → LOAD.
- LOAD:
  - If `rom_finished` → DONE.
  - Otherwise latch `rom_command`, pulse the engine's `go`, then → SEND.
- SEND: wait for the engine's `done` pulse.
  - If the latched command == 16'h1280 → RSTWAIT.
  - Otherwise → ADVANCE.
- RSTWAIT: count RESET_WAIT cycles, then → ADVANCE.
- ADVANCE: `rom_advance`=1 for one cycle, then → SETTLE.
- `rom_finished` is sampled only in LOAD.
- The same command written twice is written twice; entries are never deduplicated.
- SCCB transaction (engine):
  - Start: SIOD low while SIOC high.
  - 27 bits: SLAVE_ADDR, reg, value, each byte MSB first and followed by a ninth don't-care bit with SIOD released.
  - Stop: SIOD low → SIOC high → SIOD released.
- Bit encoding: quarter q0 SIOC low with data set up; q1 SIOC low; q2, q3 SIOC high. Data changes only while SIOC is low.
- Reset values: IDLE state, `sioc`=1, `siod_oe`=0, `rom_resend`=0, `rom_advance`=0, `busy`=0, `done`=0.
- `resetn` low mid-transaction aborts at the next edge and the bus is released immediately. The truncated write is not retried.

## Timing

- One SCCB transaction = start (4 quarters) + 27 bits (108 quarters) + stop (4 quarters) = 116·QTR_DIV clk cycles, from the `go` edge to the engine's `done` pulse.
- Per-entry overhead outside SEND/RSTWAIT: ADVANCE 1 + SETTLE 2 + LOAD 1 = 4 cycles.
- First entry: `start` edge → RESEND (1) → SETTLE (2) → LOAD (1). `go` is issued 4 cycles after `start` is accepted.
- `done` rises 1 cycle after LOAD sees `rom_finished`=1. `busy` falls on the same edge.
- Quarter-tick counter: reloads on `go`, wraps at QTR_DIV−1, and is held at 0 when the engine is idle.
- The RSTWAIT counter is ⌈log2(RESET_WAIT+1)⌉ bits wide and counts up to RESET_WAIT−1.

## Structure

- Package `ov7670_cfg_pkg` holds:
  - the FSM state enum;
  - `SCCB_SOFT_RESET` = 16'h1280;
  - `ROM_END` = 16'hFFFF;
  - `ROM_SETTLE` = 2;
  - `SCCB_BITS` = 27.
- Sub-module `sccb_write_engine` (parameters QTR_DIV, SLAVE_ADDR):
  - inputs `clk`, `resetn`, `go`, `data[15:0]`;
  - outputs `sioc`, `siod_oe`, `done`;
  - internal phase FSM: IDLE/START/BIT/STOP.
- The top level contains only the sequencing FSM and the RSTWAIT counter.

## Test plan

- Reset only, no `start`: `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0, and no ROM pulses for 1000 cycles.
- 3-entry ROM model {16'h1204, 16'h3A04, 16'hFFFF}, QTR_DIV=2:
  - decoded bus bytes are 42,12,04 then 42,3A,04;
  - each transaction is 232 cycles long;
  - `done` rises once;
  - 1 `rom_resend` and 2 `rom_advance` pulses are seen.
- ROM {16'h1280, 16'h1100, 16'hFFFF}, RESET_WAIT=50: the gap from the first engine `done` to `rom_advance` is exactly 51 cycles. The second write has no wait.
- `start` pulsed mid-SEND: ignored, and the sequence completes unchanged. `start` pulsed in DONE: `done` drops and the bytes are replayed from entry 0.
- `resetn` low in the middle of bit 10: next edge gives `sioc`=1, `siod_oe`=0, `busy`=0. After release plus `start`, the full sequence runs again.
- Bus checker throughout: SIOD (`siod_oe`) never toggles while `sioc`=1, except at start and stop conditions.
